spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, meaning SPI mode 0-3 (CPOL = mode 2/3, CPHA = mode 1/3).
REQ-002 SHALL have parameter CLKS_PER_HALF_BIT, default 2, meaning i_Clk cycles per SPI clock half-period; legal values are 2 and above.
REQ-003 SHALL have parameter CS_INACTIVE_CLKS, default 1, meaning minimum i_Clk cycles CS_n is held high between transactions (used only with the macro).
REQ-004 SHALL have port i_Clk, input, 1 bit: the single system clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port i_Rst_L, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_TX_DV, input, 1 bit: one-cycle pulse requesting transmission of i_TX_Byte.
REQ-007 SHALL have port i_TX_Byte, input, 8 bits: byte to shift out on MOSI, MSB first.
REQ-008 SHALL have port o_TX_Ready, output, 1 bit: high when a new i_TX_DV will be accepted.
REQ-009 SHALL have port o_RX_DV, output, 1 bit: one-cycle pulse marking o_RX_Byte valid.
REQ-010 SHALL have port o_RX_Byte, output, 8 bits: byte captured from MISO, MSB first.
REQ-011 SHALL have port o_SPI_Clk, output, 1 bit: SPI clock.
REQ-012 SHALL have port i_SPI_MISO, input, 1 bit: serial data from the slave.
REQ-013 SHALL have port o_SPI_MOSI, output, 1 bit: serial data to the slave.

Function
REQ-014 SHALL accept i_TX_DV only while o_TX_Ready is high; i_TX_DV while o_TX_Ready is low SHALL be ignored.
REQ-015 SHALL register i_TX_Byte on acceptance and drop o_TX_Ready in the following cycle.
REQ-016 SHALL use an FSM with states IDLE, TRANSFER, and, with the macro, CS_HOLD and CS_INACTIVE.
REQ-017 SHALL generate exactly 16 SPI clock edges per byte, spaced CLKS_PER_HALF_BIT cycles apart, with the first edge CLKS_PER_HALF_BIT cycles after acceptance; o_SPI_Clk SHALL idle at CPOL.
REQ-018 When CPHA=0, SHALL drive the MOSI MSB in the cycle after acceptance, sample MISO on leading edges, and update MOSI on trailing edges.
REQ-019 When CPHA=1, SHALL update MOSI on leading edges and sample MISO on trailing edges.
REQ-020 SHALL, in the cycle after the 16th edge, pulse o_RX_DV for one cycle, present o_RX_Byte, and (without the macro) reassert o_TX_Ready; one byte therefore takes 16*CLKS_PER_HALF_BIT+1 cycles from acceptance to ready.
REQ-021 SHALL hold o_RX_Byte stable until the next o_RX_DV.
REQ-022 SHALL accept i_TX_DV in the same cycle o_TX_Ready reasserts, giving back-to-back bytes with no extra gap.

Reset
REQ-023 On i_Rst_L low, SHALL immediately (also mid-transfer) abort and set: FSM to IDLE, o_SPI_Clk to CPOL, o_SPI_MOSI 0, o_RX_DV 0, o_RX_Byte 8'h00, o_TX_Ready 0, o_SPI_CS_n 1.
REQ-024 SHALL raise o_TX_Ready in the first i_Clk edge after reset release.

Configuration
REQ-025 The macro SPI_MASTER_CS_CTRL_EN, when defined, SHALL add port i_TX_Count (input, 2 bits: bytes per transaction, 0 treated as 1, latched on the first byte) and port o_SPI_CS_n (output, 1 bit, active-low chip select).
REQ-026 With the macro, SHALL drive o_SPI_CS_n low in the cycle after the first accepted byte and keep it low until the latched count of bytes completes.
REQ-027 With the macro, between bytes SHALL enter CS_HOLD with o_TX_Ready high and CS_n low, waiting indefinitely.
REQ-028 With the macro, after the last byte SHALL raise o_SPI_CS_n and stay in CS_INACTIVE with o_TX_Ready low for CS_INACTIVE_CLKS cycles.
REQ-029 Without the macro, i_TX_Count and o_SPI_CS_n SHALL NOT exist; chip select is external.

Verification
REQ-030 Mode 0, CLKS_PER_HALF_BIT=2, TX 8'hA5 with MISO looped to MOSI -> RX_DV after 33 cycles, RX_Byte 8'hA5, 8 rising edges on o_SPI_Clk.
REQ-031 Modes 1, 2, 3 each: TX 8'h3C, slave model returns 8'hC3 -> RX_Byte 8'hC3, o_SPI_Clk idles at CPOL.
REQ-032 Back-to-back: TX 8'h01 then 8'hFF, each DV in the cycle ready rises -> two RX_DV pulses exactly 33 cycles apart.
REQ-033 TX_DV while ready is low -> ignored, in-flight byte unchanged.
REQ-034 With the macro: count=2, bytes 8'h12 then 8'h34 -> CS_n stays low across both; CS_n high and ready low for CS_INACTIVE_CLKS cycles after.
REQ-035 Reset asserted at edge 7 -> outputs at reset values immediately; a new byte after release completes correctly.

Source files
------------

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-byte SPI master, modes 0-3, MSB first, programmable
//               SPI clock rate. Define SPI_MASTER_CS_CTRL_EN to add internal
//               multi-byte chip-select control (i_TX_Count / o_SPI_CS_n).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_INACTIVE_CLKS  = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
`ifdef SPI_MASTER_CS_CTRL_EN
    ,
    input  logic [1:0] i_TX_Count,
    output logic       o_SPI_CS_n
`endif
);

    localparam logic c_CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
    localparam logic c_CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);
    localparam int   c_CNT_W = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_HALF_BIT - 1);

    if (CLKS_PER_HALF_BIT < 2 || CS_INACTIVE_CLKS < 0) begin : g_param_check
        $error("spi_master: CLKS_PER_HALF_BIT must be >= 2 and CS_INACTIVE_CLKS >= 0");
    end

`ifdef SPI_MASTER_CS_CTRL_EN
    localparam int c_GAP_W = $clog2(CS_INACTIVE_CLKS + 1) + 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(CS_INACTIVE_CLKS);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        TRANSFER    = 2'd1,
        CS_HOLD     = 2'd2,
        CS_INACTIVE = 2'd3
    } state_t;

    logic [1:0]         r_bytes_left;
    logic [c_GAP_W-1:0] r_gap_cnt;
`else
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRANSFER = 2'd1
    } state_t;
`endif

    state_t             r_state;
    logic [c_CNT_W-1:0] r_clk_cnt;
    logic [4:0]         r_edge_cnt;
    logic [7:0]         r_tx_byte;
    logic [2:0]         r_tx_bit;
    logic [7:0]         r_rx_shift;

    logic       w_edge;
    logic       w_leading;
    logic       w_sample;
    logic       w_shift;
    logic       w_last;
    logic       w_accept;
    logic [7:0] w_rx_next;

    // r_edge_cnt counts edges still to come: even values are leading edges.
    assign w_edge    = (r_state == TRANSFER) && (r_clk_cnt == c_HALF_LAST);
    assign w_leading = ~r_edge_cnt[0];
    assign w_sample  = w_edge && (c_CPHA ? ~w_leading : w_leading);
    assign w_shift   = w_edge && (c_CPHA ? w_leading : ~w_leading) && (r_edge_cnt != 5'd1);
    assign w_last    = w_edge && (r_edge_cnt == 5'd1);
    assign w_accept  = o_TX_Ready && i_TX_DV;
    assign w_rx_next = w_sample ? {r_rx_shift[6:0], i_SPI_MISO} : r_rx_shift;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state      <= IDLE;
            r_clk_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_tx_byte    <= '0;
            r_tx_bit     <= '0;
            r_rx_shift   <= '0;
            o_TX_Ready   <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= '0;
            o_SPI_Clk    <= c_CPOL;
            o_SPI_MOSI   <= 1'b0;
`ifdef SPI_MASTER_CS_CTRL_EN
            o_SPI_CS_n   <= 1'b1;
            r_bytes_left <= '0;
            r_gap_cnt    <= '0;
`endif
        end else begin
            o_RX_DV <= 1'b0;

            case (r_state)
                IDLE: begin
                    o_TX_Ready <= 1'b1;
                end

                TRANSFER: begin
                    if (w_edge) begin
                        r_clk_cnt  <= '0;
                        o_SPI_Clk  <= ~o_SPI_Clk;
                        r_edge_cnt <= r_edge_cnt - 5'd1;
                    end else begin
                        r_clk_cnt  <= r_clk_cnt + c_CNT_W'(1);
                    end

                    if (w_sample) begin
                        r_rx_shift <= w_rx_next;
                    end

                    if (w_shift) begin
                        o_SPI_MOSI <= r_tx_byte[r_tx_bit];
                        r_tx_bit   <= r_tx_bit - 3'd1;
                    end

                    if (w_last) begin
                        o_RX_DV   <= 1'b1;
                        o_RX_Byte <= w_rx_next;
`ifdef SPI_MASTER_CS_CTRL_EN
                        r_bytes_left <= r_bytes_left - 2'd1;
                        if (r_bytes_left == 2'd1) begin
                            r_state    <= CS_INACTIVE;
                            o_SPI_CS_n <= 1'b1;
                            r_gap_cnt  <= c_GAP_W'(1);
                        end else begin
                            r_state    <= CS_HOLD;
                            o_TX_Ready <= 1'b1;
                        end
`else
                        r_state    <= IDLE;
                        o_TX_Ready <= 1'b1;
`endif
                    end
                end

`ifdef SPI_MASTER_CS_CTRL_EN
                CS_HOLD: begin
                    o_TX_Ready <= 1'b1;
                end

                CS_INACTIVE: begin
                    if (r_gap_cnt >= c_GAP_LAST) begin
                        r_state    <= IDLE;
                        o_TX_Ready <= 1'b1;
                    end else begin
                        r_gap_cnt  <= r_gap_cnt + c_GAP_W'(1);
                    end
                end
`endif

                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Acceptance overrides the per-state defaults above.
            if (w_accept) begin
                r_state    <= TRANSFER;
                o_TX_Ready <= 1'b0;
                r_tx_byte  <= i_TX_Byte;
                r_clk_cnt  <= '0;
                r_edge_cnt <= 5'd16;
                if (c_CPHA) begin
                    r_tx_bit   <= 3'd7;
                end else begin
                    o_SPI_MOSI <= i_TX_Byte[7];
                    r_tx_bit   <= 3'd6;
                end
`ifdef SPI_MASTER_CS_CTRL_EN
                o_SPI_CS_n <= 1'b0;
                if (r_state == IDLE) begin
                    r_bytes_left <= (i_TX_Count == 2'd0) ? 2'd1 : i_TX_Count;
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master
// Description : Directed bench for spi_master; one DUT per SPI mode, all fed
//               the same byte stream, each with its own slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int c_HALF = 2;
    localparam int c_GAP  = 2;
    localparam int c_LAT  = 16 * c_HALF + 1;
`ifdef SPI_MASTER_CS_CTRL_EN
    localparam int c_B2B  = c_LAT + c_GAP;
`else
    localparam int c_B2B  = c_LAT;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic [3:0] ready;
    logic [3:0] rx_dv;
    logic [3:0] sclk;
    logic [3:0] mosi;
    logic [3:0] miso;
    logic [7:0] rx_byte [4];
    logic [7:0] cap [4];
    logic       loop0;
    logic       slv_load;
    logic [7:0] slv_data;
`ifdef SPI_MASTER_CS_CTRL_EN
    logic [1:0] tx_count;
    logic [3:0] cs_n;
`endif

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam logic CPOL = (m >= 2);
        localparam logic CPHA = (m % 2 == 1);

        logic [7:0] r_slv  = 8'h00;
        logic [7:0] r_cap  = 8'h00;
        logic       r_miso = 1'b0;
        logic       r_prev = CPOL;
        int         r_tog  = 0;
        int         r_rise = 0;

        spi_master #(
            .SPI_MODE          (m),
            .CLKS_PER_HALF_BIT (c_HALF),
            .CS_INACTIVE_CLKS  (c_GAP)
        ) u_dut (
            .i_Clk      (clk),
            .i_Rst_L    (rst_n),
            .i_TX_DV    (tx_dv),
            .i_TX_Byte  (tx_byte),
            .o_TX_Ready (ready[m]),
            .o_RX_DV    (rx_dv[m]),
            .o_RX_Byte  (rx_byte[m]),
            .o_SPI_Clk  (sclk[m]),
            .i_SPI_MISO (miso[m]),
            .o_SPI_MOSI (mosi[m])
`ifdef SPI_MASTER_CS_CTRL_EN
            ,
            .i_TX_Count (tx_count),
            .o_SPI_CS_n (cs_n[m])
`endif
        );

        assign miso[m] = (m == 0 && loop0) ? mosi[m] : r_miso;
        assign cap[m]  = r_cap;

        // Slave: drives MISO on its launch edge, captures MOSI on the other.
        always @(negedge clk) begin
            r_prev <= sclk[m];
            if (slv_load) begin
                r_slv  <= slv_data;
                r_miso <= CPHA ? 1'b0 : slv_data[7];
            end else if (sclk[m] != r_prev) begin
                r_tog <= r_tog + 1;
                if (sclk[m]) r_rise <= r_rise + 1;
                if ((sclk[m] != CPOL) == CPHA) begin
                    r_miso <= CPHA ? r_slv[7] : r_slv[6];
                    r_slv  <= r_slv << 1;
                end else begin
                    r_cap  <= {r_cap[6:0], mosi[m]};
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input logic [7:0] b, output int t_drv);
        @(negedge clk);
        tx_byte = b;
        tx_dv   = 1'b1;
        t_drv   = cyc;
        @(negedge clk);
        tx_dv   = 1'b0;
    endtask

    task automatic wait_dv(output int t);
        t = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rx_dv[0]) begin
                t = cyc;
                break;
            end
        end
        chk("rx_dv_seen", 32'(t >= 0), 32'd1);
    endtask

    task automatic load_slv(input logic [7:0] d);
        @(negedge clk);
        slv_data = d;
        slv_load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        slv_load = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_sclk"},  32'(sclk),  32'hC);
        chk({tag, "_mosi"},  32'(mosi),  32'h0);
        chk({tag, "_rxdv"},  32'(rx_dv), 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_rxbyte_m%0d", tag, k), 32'(rx_byte[k]), 32'h0);
`ifdef SPI_MASTER_CS_CTRL_EN
        chk({tag, "_csn"}, 32'(cs_n), 32'hF);
`endif
    endtask

    initial begin
        int t0, t1, t2, base, n;
        rst_n    = 1'b0;
        tx_dv    = 1'b0;
        tx_byte  = 8'h00;
        loop0    = 1'b1;
        slv_load = 1'b0;
        slv_data = 8'h00;
`ifdef SPI_MASTER_CS_CTRL_EN
        tx_count = 2'd0;
`endif
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(ready), 32'hF);

        // Mode 0 loopback of 8'hA5.
        load_slv(8'hC3);
        loop0 = 1'b1;
        base  = g_mode[0].r_rise;
        send(8'hA5, t0);
        wait_dv(t1);
        chk("latency_a5", 32'(t1 - t0), 32'(c_LAT));
        chk("rx_a5_m0", 32'(rx_byte[0]), 32'hA5);
        @(negedge clk);
        chk("rises_a5", 32'(g_mode[0].r_rise - base), 32'd8);
        chk("sclk_idle_a5", 32'(sclk), 32'hC);

        // All modes: TX 3C against slaves returning C3; a busy DV must be ignored.
        loop0 = 1'b0;
        load_slv(8'hC3);
        send(8'h3C, t0);
        repeat (8) @(negedge clk);
        chk("busy_ready_low", 32'(ready), 32'h0);
        tx_byte = 8'h00;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
        wait_dv(t1);
        for (int k = 0; k < 4; k++) chk($sformatf("rx_c3_m%0d", k), 32'(rx_byte[k]), 32'hC3);
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("mosi_3c_m%0d", k), 32'(cap[k]), 32'h3C);
        chk("sclk_idle_3c", 32'(sclk), 32'hC);
        n = 0;
        repeat (60) begin
            @(negedge clk);
            if (rx_dv[0]) n++;
        end
        chk("busy_dv_ignored", 32'(n), 32'd0);
        chk("ready_idle", 32'(ready), 32'hF);
        chk("rx_hold_m1", 32'(rx_byte[1]), 32'hC3);

        // Back-to-back 01 then FF, DV driven as soon as ready is seen.
        loop0 = 1'b1;
        load_slv(8'h00);
        send(8'h01, t0);
        wait_dv(t1);
        chk("rx_01_m0", 32'(rx_byte[0]), 32'h01);
        for (int i = 0; i < 20 && !ready[0]; i++) @(negedge clk);
        tx_byte = 8'hFF;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
        wait_dv(t2);
        chk("b2b_spacing", 32'(t2 - t1), 32'(c_B2B));
        chk("rx_ff_m0", 32'(rx_byte[0]), 32'hFF);

        // Abort after the 7th SPI edge, then a clean byte.
        repeat (10) @(negedge clk);
        base = g_mode[0].r_tog;
        send(8'hFF, t0);
        for (int i = 0; i < 100 && (g_mode[0].r_tog - base) < 7; i++) @(negedge clk);
        chk("edge7_reached", 32'(g_mode[0].r_tog - base), 32'd7);
        chk("mosi_busy_ff", 32'(mosi), 32'hF);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 32'(ready), 32'hF);
        load_slv(8'hC3);
        send(8'h5A, t0);
        wait_dv(t1);
        chk("latency_5a", 32'(t1 - t0), 32'(c_LAT));
        chk("rx_5a_m0", 32'(rx_byte[0]), 32'h5A);
        for (int k = 1; k < 4; k++) chk($sformatf("rx_post_abort_m%0d", k), 32'(rx_byte[k]), 32'hC3);
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("mosi_5a_m%0d", k), 32'(cap[k]), 32'h5A);

`ifdef SPI_MASTER_CS_CTRL_EN
        // Two-byte transaction under one chip select.
        repeat (5) @(negedge clk);
        tx_count = 2'd2;
        chk("cs_idle_high", 32'(cs_n), 32'hF);
        send(8'h12, t0);
        chk("cs_low_first", 32'(cs_n), 32'h0);
        tx_count = 2'd0;
        wait_dv(t1);
        chk("rx_12_m0", 32'(rx_byte[0]), 32'h12);
        repeat (5) @(negedge clk);
        chk("cs_hold_low", 32'(cs_n), 32'h0);
        chk("cs_hold_ready", 32'(ready), 32'hF);
        send(8'h34, t0);
        wait_dv(t1);
        chk("rx_34_m0", 32'(rx_byte[0]), 32'h34);
        chk("cs_high_after", 32'(cs_n), 32'hF);
        chk("gap_ready_low0", 32'(ready), 32'h0);
        @(negedge clk);
        chk("gap_ready_low1", 32'(ready), 32'h0);
        @(negedge clk);
        chk("gap_ready_back", 32'(ready), 32'hF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
